// File: rtl/mac_result_drain.sv
// Snapshots all MAC lane results on a capture pulse and streams them out one word per beat.
// Optional running checksum of each drained snapshot when MAC_DRAIN_CHECKSUM_EN is defined.
module mac_result_drain #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 16,
  parameter int unsigned IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*DW-1:0]   mac_out_flat,
  input  logic                  capture,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  overrun,
  input  logic                  overrun_clr
`ifdef MAC_DRAIN_CHECKSUM_EN
  ,
  output logic [DW-1:0]         csum_out,
  output logic                  csum_valid
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e state_q, state_d;

  logic [DW-1:0]    snap_q [LANES];
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             hs, last_hs, load, drop;
  logic [IDX_W-1:0] nxt_idx;

  assign hs      = out_valid_q && out_ready;
  assign last_hs = hs && out_last_q;
  assign load    = capture && ((state_q == IDLE) || last_hs);
  assign drop    = capture && (state_q == STREAM) && !last_hs;
  assign nxt_idx = out_idx_q + IDX_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = STREAM;
      STREAM:  if (last_hs && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; a stalled beat simply keeps the held values
  always_comb begin
    out_valid_d = (state_d == STREAM);
    busy_d      = (state_d == STREAM);
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_idx_d  = '0;
      out_data_d = mac_out_flat[DW-1:0];
      out_last_d = (LANES == 1);
    end else if (last_hs) begin
      out_idx_d  = '0;
      out_data_d = '0;
      out_last_d = 1'b0;
    end else if (hs) begin
      out_idx_d  = nxt_idx;
      out_data_d = snap_q[nxt_idx];
      out_last_d = (nxt_idx == LAST_IDX);
    end
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(LANES); k++) snap_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < int'(LANES); k++) snap_q[k] <= mac_out_flat[k*DW +: DW];
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;

`ifdef MAC_DRAIN_CHECKSUM_EN
  logic [DW-1:0] sum_q, csum_q;
  logic          csum_valid_q;

  // Running sum of accepted words; total published the cycle after the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q        <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= last_hs;
      if (last_hs) begin
        csum_q <= sum_q + out_data_q;
        sum_q  <= '0;
      end else if (load) begin
        sum_q <= '0;
      end else if (hs) begin
        sum_q <= sum_q + out_data_q;
      end
    end
  end

  assign csum_out   = csum_q;
  assign csum_valid = csum_valid_q;
`endif

endmodule
